axis_s_fifo: RTL and testbench
==============================

# axis_s_fifo

Parametrised AXI-Stream slave with an internal FIFO, tkeep/tlast support and packet accounting. Generalises the single-beat, one-register slave to a DEPTH-entry buffered receiver: it accepts bursts at full rate while the user side drains at its own pace. It sits between an upstream AXI-Stream master and the user application, and exposes a first-word-fall-through valid/ready read port plus status flags.

## Interface
- DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
- DEPTH, 16, FIFO entries; power of 2, ≥ 2.
- KEEP_WIDTH, DATA_WIDTH/8, derived; do not override.
- CNT_WIDTH, $clog2(DEPTH+1), derived; do not override.

- aclk  in  1  clock; all logic on the rising edge.
- areset_n  in  1  reset, synchronous, active-low.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  slave can accept a beat.
- s_tdata  in  DATA_WIDTH  upstream data.
- s_tkeep  in  KEEP_WIDTH  byte enables.
- s_tlast  in  1  last beat of packet.
- m_valid  out  1  head entry available to the user.
- m_ready  in  1  user consumes the head entry.
- m_data  out  DATA_WIDTH  head entry data.
- m_keep  out  KEEP_WIDTH  head entry tkeep.
- m_last  out  1  head entry tlast.
- count  out  CNT_WIDTH  entries currently stored.
- pkt_count  out  CNT_WIDTH  complete packets (tlast stored) in the FIFO.
- finish  out  1  one-cycle pulse: a tlast beat was accepted.
- err  out  1  sticky protocol error.
- err_clr  in  1  clears err.

## Operation
- Push: on a cycle with s_tvalid & s_tready, write {tdata, tkeep, tlast} at wr_ptr, then wr_ptr+1 with wrap modulo DEPTH.
- Pop: on a cycle with m_valid & m_ready, advance rd_ptr by 1 modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- s_tready = rst_done & (count != DEPTH).
  - rst_done is a register: 0 in reset, 1 from the first edge after release.
  - s_tready has no combinational path from s_tvalid or m_ready.
- m_valid = (count != 0). m_data, m_keep and m_last come directly from mem[rd_ptr] (FWFT).
- pkt_count: +1 on a push with tlast; −1 on a pop with m_last; unchanged when both occur in the same cycle.
- finish: registered; high for exactly one cycle after each push with tlast. It is not held for the user.
- err: set on any push where tkeep == 0, or where tlast == 0 and tkeep is not all-ones.
  - err_clr clears err. If clear and set occur in the same cycle, set wins.
  - Error beats are stored unchanged.
- m_* and s_* handshakes are independent; the block holds no state machine beyond the pointers and counters.

## Timing
- Reset values: s_tready 0, m_valid 0, count 0, pkt_count 0, finish 0, err 0; pointers 0. m_data, m_keep and m_last read the memory at rd_ptr 0; their value is don't-care while m_valid is 0.
- Reset asserted mid-operation flushes all contents on that edge; no beat is accepted in that cycle.
- Throughput: 1 beat/cycle in and out when neither side stalls.
- Latency: a beat pushed at edge N appears on m_* with m_valid = 1 after edge N, i.e. usable in cycle N+1.
- Full boundary (count == DEPTH): s_tready = 0. A pop at edge N makes s_tready = 1 in cycle N+1. There is no same-cycle pass-through.
- Empty boundary: m_valid = 0, so no pop. Push into empty gives m_valid = 1 the next cycle.
- count never exceeds DEPTH and never underflows. m_ready is ignored while m_valid = 0; s_tvalid is ignored while s_tready = 0.

## Test plan
- Reset then idle: all outputs 0 during reset. s_tready = 1 one cycle after areset_n rises; m_valid stays 0.
- Single 4-beat packet (0xA0..0xA3, tkeep 0xF, tlast on 0xA3), m_ready = 0:
  - count reaches 4; pkt_count = 1; finish pulses once, the cycle after the 0xA3 handshake.
  - Draining yields 0xA0..0xA3 in order, m_last only on 0xA3, and pkt_count returns to 0.
- Fill with DEPTH = 16 and m_ready = 0:
  - s_tready drops after the 16th beat; the 17th beat is held by the master and not lost.
  - One pop makes s_tready high the next cycle; the 17th beat is then accepted; count = 16.
- Streaming with s_tvalid = m_ready = 1 for 100 cycles and random data: count stays 1 after the first beat, and output order equals input order (scoreboard).
- Pointer wrap: random stalls on both sides over more than 3×DEPTH beats; data integrity holds and count tracks the scoreboard occupancy every cycle.
- Protocol error and reset mid-operation:
  - A non-last beat with tkeep 0x3 sets err; err stays set until an err_clr pulse.
  - err_clr on the same cycle as a new error beat leaves err = 1.
  - Reset asserted with count = 5 returns count and pkt_count to 0 on that edge.

Source files
------------

// File: rtl/axis_s_fifo.sv
// axis_s_fifo: AXI-Stream slave feeding a DEPTH-entry first-word-fall-through
// FIFO. Each entry holds {tdata, tkeep, tlast}. The block also counts stored
// entries and complete packets, pulses finish for every accepted tlast beat,
// and keeps a sticky error flag for malformed tkeep. The tkeep rule is that a
// beat must have at least one byte enabled, and only the last beat of a packet
// may be partial. Beats that break this rule are still stored unchanged.
module axis_s_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_WIDTH-1:0] m_keep,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  finish,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [KEEP_WIDTH-1:0] r_mem_keep [DEPTH];
  logic                  r_mem_last [DEPTH];

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_pkt_count;
  logic                  r_rst_done;
  logic                  r_finish;
  logic                  r_err;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_bad_keep;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic [CNT_WIDTH-1:0]  w_pkt_nxt;
  logic                  w_err_nxt;

  // Handshakes depend only on registered state, so ready never follows
  // s_tvalid or m_ready combinationally. Gating push with areset_n keeps the
  // memory untouched on the flushing edge.
  assign s_tready = r_rst_done & (r_count != CNT_WIDTH'(DEPTH));
  assign m_valid  = (r_count != {CNT_WIDTH{1'b0}});
  assign w_push   = s_tvalid & s_tready & areset_n;
  assign w_pop    = m_valid & m_ready;

  assign w_bad_keep = (s_tkeep == {KEEP_WIDTH{1'b0}}) |
                      (~s_tlast & (s_tkeep != {KEEP_WIDTH{1'b1}}));

  // First-word-fall-through read straight out of the head entry.
  assign m_data    = r_mem_data[r_rd_ptr];
  assign m_keep    = r_mem_keep[r_rd_ptr];
  assign m_last    = r_mem_last[r_rd_ptr];
  assign count     = r_count;
  assign pkt_count = r_pkt_count;
  assign finish    = r_finish;
  assign err       = r_err;

  // Next-state values for the occupancy, packet and error registers.
  always_comb begin
    w_count_nxt = r_count;
    w_pkt_nxt   = r_pkt_count;
    w_err_nxt   = r_err;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_WIDTH'(1);
      2'b01:   w_count_nxt = r_count - CNT_WIDTH'(1);
      default: w_count_nxt = r_count;
    endcase
    case ({w_push & s_tlast, w_pop & m_last})
      2'b10:   w_pkt_nxt = r_pkt_count + CNT_WIDTH'(1);
      2'b01:   w_pkt_nxt = r_pkt_count - CNT_WIDTH'(1);
      default: w_pkt_nxt = r_pkt_count;
    endcase
    // A new error in the same cycle as a clear request keeps the flag set.
    if (w_push & w_bad_keep) begin
      w_err_nxt = 1'b1;
    end else if (err_clr) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Pointers, counters and status flags with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CNT_WIDTH{1'b0}};
      r_pkt_count <= {CNT_WIDTH{1'b0}};
      r_rst_done  <= 1'b0;
      r_finish    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rst_done  <= 1'b1;
      r_count     <= w_count_nxt;
      r_pkt_count <= w_pkt_nxt;
      r_finish    <= w_push & s_tlast;
      r_err       <= w_err_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Storage array; contents need no reset because m_* are only meaningful
  // while m_valid is high.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= s_tdata;
      r_mem_keep[r_wr_ptr] <= s_tkeep;
      r_mem_last[r_wr_ptr] <= s_tlast;
    end
  end

endmodule

// File: tb/tb_axis_s_fifo.sv
// tb_axis_s_fifo: directed bench for axis_s_fifo. A queue-based reference
// model tracks accepted beats, and a negedge process compares every output
// against it each cycle. Directed sequences add literal expectations.
module tb_axis_s_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int KW    = DW / 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_count;
  logic          finish;
  logic          err;
  logic          err_clr;

  axis_s_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last),
    .count(count), .pkt_count(pkt_count), .finish(finish),
    .err(err), .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t q[$];
  logic  md_rst_done = 1'b0;
  logic  md_finish   = 1'b0;
  logic  md_err      = 1'b0;
  logic  cmp_en      = 1'b0;
  int    checks      = 0;
  int    failures    = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lasts_in_queue();
    int n = 0;
    foreach (q[i]) if (q[i].l) n++;
    return n;
  endfunction

  // Reference model: apply the handshake rules at every rising edge.
  always @(posedge aclk) begin
    bit    push;
    bit    pop;
    beat_t b;
    if (!areset_n) begin
      q.delete();
      md_rst_done = 1'b0;
      md_finish   = 1'b0;
      md_err      = 1'b0;
    end else begin
      push = s_tvalid && md_rst_done && (q.size() < DEPTH);
      pop  = (q.size() != 0) && m_ready;
      if (pop) void'(q.pop_front());
      if (push) begin
        b.d = s_tdata; b.k = s_tkeep; b.l = s_tlast;
        q.push_back(b);
      end
      md_finish = push && s_tlast;
      if (push && ((s_tkeep == 4'h0) || (!s_tlast && s_tkeep != 4'hF))) md_err = 1'b1;
      else if (err_clr) md_err = 1'b0;
      md_rst_done = 1'b1;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge aclk) begin
    if (cmp_en) begin
      check("s_tready", 64'(s_tready), 64'(md_rst_done && (q.size() != DEPTH)));
      check("m_valid", 64'(m_valid), 64'(q.size() != 0));
      check("count", 64'(count), 64'(q.size()));
      check("pkt_count", 64'(pkt_count), 64'(lasts_in_queue()));
      check("finish", 64'(finish), 64'(md_finish));
      check("err", 64'(err), 64'(md_err));
      if (q.size() != 0) begin
        check("m_data", 64'(m_data), 64'(q[0].d));
        check("m_keep", 64'(m_keep), 64'(q[0].k));
        check("m_last", 64'(m_last), 64'(q[0].l));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    m_ready = 1'b1;
    while (count != 5'd0 && n < 40) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    check(nm, 64'(count), 64'd0);
  endtask

  initial begin
    areset_n = 1'b0; s_tvalid = 1'b0; s_tdata = 32'h0; s_tkeep = 4'h0;
    s_tlast = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    tick();
    cmp_en = 1'b1;
    repeat (2) tick();

    // Reset state and release.
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_pkt", 64'(pkt_count), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    areset_n = 1'b1;
    check("rel_s_tready_pre", 64'(s_tready), 64'd0);
    tick();
    check("rel_s_tready", 64'(s_tready), 64'd1);
    check("rel_m_valid", 64'(m_valid), 64'd0);

    // Single 4-beat packet with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hA0 + 32'(i); s_tkeep = 4'hF; s_tlast = (i == 3);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("pkt_count4", 64'(count), 64'd4);
    check("pkt_pkt1", 64'(pkt_count), 64'd1);
    check("pkt_finish_hi", 64'(finish), 64'd1);
    tick();
    check("pkt_finish_lo", 64'(finish), 64'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pkt_drain_data", 64'(m_data), 64'hA0 + 64'(i));
      check("pkt_drain_last", 64'(m_last), 64'(i == 3));
      tick();
    end
    m_ready = 1'b0;
    check("pkt_drain_count", 64'(count), 64'd0);
    check("pkt_drain_pkt", 64'(pkt_count), 64'd0);

    // Fill to DEPTH, hold the 17th beat, free one slot, accept it.
    for (int i = 0; i < DEPTH; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hB0 + 32'(i); s_tkeep = 4'hF; s_tlast = 1'b0;
      tick();
    end
    check("full_s_tready", 64'(s_tready), 64'd0);
    check("full_count", 64'(count), 64'd16);
    s_tdata = 32'hC17;
    repeat (3) tick();
    check("full_hold_count", 64'(count), 64'd16);
    check("full_head", 64'(m_data), 64'hB0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("full_pop_ready", 64'(s_tready), 64'd1);
    check("full_pop_count", 64'(count), 64'd15);
    check("full_pop_head", 64'(m_data), 64'hB1);
    tick();
    s_tvalid = 1'b0;
    check("full_refill_count", 64'(count), 64'd16);
    drain("full_drain");

    // Full-rate streaming: occupancy stays at one.
    s_tvalid = 1'b1; m_ready = 1'b1; s_tkeep = 4'hF; s_tlast = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_tdata = $urandom;
      tick();
      check("stream_count", 64'(count), 64'd1);
    end
    s_tvalid = 1'b0;
    tick();
    m_ready = 1'b0;
    check("stream_end_count", 64'(count), 64'd0);

    // Random stalls on both sides to wrap the pointers several times.
    for (int i = 0; i < 200; i++) begin
      s_tvalid = 1'($urandom_range(0, 1));
      m_ready  = 1'($urandom_range(0, 1));
      s_tdata  = $urandom;
      s_tlast  = 1'($urandom_range(0, 1));
      s_tkeep  = 4'hF;
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain("wrap_drain");

    // Protocol errors and clear priority.
    s_tvalid = 1'b1; s_tdata = 32'hE0; s_tkeep = 4'h3; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0;
    check("err_set", 64'(err), 64'd1);
    repeat (3) tick();
    check("err_sticky", 64'(err), 64'd1);
    check("err_beat_keep", 64'(m_keep), 64'h3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 64'(err), 64'd0);
    err_clr = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hE1; s_tkeep = 4'h0; s_tlast = 1'b1;
    tick();
    err_clr = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    check("err_set_wins", 64'(err), 64'd1);
    check("err_count", 64'(count), 64'd2);
    drain("err_drain");

    // Reset in the middle of operation flushes everything on that edge.
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hD0 + 32'(i); s_tkeep = 4'hF; s_tlast = (i == 2);
      tick();
    end
    s_tlast = 1'b0;
    check("mid_count5", 64'(count), 64'd5);
    check("mid_pkt1", 64'(pkt_count), 64'd1);
    areset_n = 1'b0;
    tick();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_pkt", 64'(pkt_count), 64'd0);
    check("mid_rst_ready", 64'(s_tready), 64'd0);
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    s_tvalid = 1'b0; areset_n = 1'b1;
    tick();
    check("mid_rel_ready", 64'(s_tready), 64'd1);
    check("mid_rel_count", 64'(count), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
